// File: rtl/lights_pkg.sv
// rtl/lights_pkg.sv - shared widths, FSM state and read-owner tag for the lights BRAM arbiter
package lights_pkg;
  localparam int LIGHTS_ADDR_W = 10;
  localparam int LIGHTS_DATA_W = 16;
  localparam int LIGHTS_DEPTH  = 1024;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_CLEAR = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_HOST   = 1'b0,
    OWN_RENDER = 1'b1
  } owner_e;
endpackage

// File: rtl/lights_bram_arbiter_if.sv
// rtl/lights_bram_arbiter_if.sv - host, render, clear and BRAM signals of the lights arbiter
interface lights_bram_arbiter_if
  import lights_pkg::*;
#(
  parameter int ADDR_W = LIGHTS_ADDR_W,
  parameter int DATA_W = LIGHTS_DATA_W
);
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              clear_start;
  logic              clear_busy;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic [DATA_W-1:0] bram_dout;

  modport slave (
    input  host_req, host_we, host_addr, host_wdata, rd_req, rd_addr, clear_start, bram_dout,
    output host_gnt, host_rvalid, host_rdata, rd_gnt, rd_valid, rd_data, clear_busy,
           bram_we, bram_addr, bram_din
  );

  modport master (
    output host_req, host_we, host_addr, host_wdata, rd_req, rd_addr, clear_start, bram_dout,
    input  host_gnt, host_rvalid, host_rdata, rd_gnt, rd_valid, rd_data, clear_busy,
           bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/lights_clear_seq.sv
// rtl/lights_clear_seq.sv - zero-fill address sequencer; busy for DEPTH cycles, done on the last word
module lights_clear_seq #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    busy_d = busy_q;
    addr_d = addr_q;
    done   = 1'b0;
    if (busy_q) begin
      if (addr_q == LAST) begin
        done   = 1'b1;
        busy_d = 1'b0;
        addr_d = '0;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end else if (start) begin
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      addr_q <= '0;
    end else begin
      busy_q <= busy_d;
      addr_q <= addr_d;
    end
  end

  assign clr_addr = addr_q;
  assign busy     = busy_q;
endmodule

// File: rtl/lights_bram_arbiter.sv
// rtl/lights_bram_arbiter.sv - single-port lights BRAM arbiter (render priority, host starvation guard, zero-fill)
// Optional conflict counter enabled by LIGHTS_ARB_STATS_EN.
module lights_bram_arbiter
  import lights_pkg::*;
#(
  parameter int ADDR_W   = LIGHTS_ADDR_W,
  parameter int DATA_W   = LIGHTS_DATA_W,
  parameter int DEPTH    = LIGHTS_DEPTH,
  parameter int MAX_WAIT = 4
) (
  input logic                  clk,
  input logic                  rst,
  lights_bram_arbiter_if.slave bus
`ifdef LIGHTS_ARB_STATS_EN
  ,
  input  logic                 stats_clr,
  output logic [15:0]          conflict_cnt
`endif
);
  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  arb_state_e        state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pend_q, pend_d;
  owner_e            owner_q, owner_d;

  logic              host_gnt, rd_gnt, bram_we;
  logic [DATA_W-1:0] bram_din;
  logic              clr_start, clr_busy, clr_done;
  logic [ADDR_W-1:0] clr_addr;

  lights_clear_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .start    (clr_start),
    .clr_addr (clr_addr),
    .busy     (clr_busy),
    .done     (clr_done)
  );

  // Everything is gated by rst so a reset cycle (even mid-clear) issues no grant and no write.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    addr_d    = addr_q;
    pend_d    = 1'b0;
    owner_d   = owner_q;
    host_gnt  = 1'b0;
    rd_gnt    = 1'b0;
    bram_we   = 1'b0;
    bram_din  = '0;
    clr_start = 1'b0;
    if (!rst) begin
      case (state_q)
        ARB_IDLE: begin
          host_gnt = bus.host_req && (!bus.rd_req || wait_q == WAIT_LIM);
          rd_gnt   = bus.rd_req && !host_gnt;
          if (host_gnt) begin
            addr_d   = bus.host_addr;
            bram_we  = bus.host_we;
            bram_din = bus.host_wdata;
            pend_d   = !bus.host_we;
            owner_d  = OWN_HOST;
          end else if (rd_gnt) begin
            addr_d  = bus.rd_addr;
            pend_d  = 1'b1;
            owner_d = OWN_RENDER;
          end
          wait_d = (bus.host_req && !host_gnt) ? wait_q + 4'd1 : 4'd0;
          if (bus.clear_start) begin
            clr_start = 1'b1;
            state_d   = ARB_CLEAR;
          end
        end
        ARB_CLEAR: begin
          bram_we = 1'b1;
          addr_d  = clr_addr;
          if (clr_done) state_d = ARB_IDLE;
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      wait_q  <= '0;
      addr_q  <= '0;
      pend_q  <= 1'b0;
      owner_q <= OWN_HOST;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      owner_q <= owner_d;
    end
  end

  assign bus.host_gnt    = host_gnt;
  assign bus.rd_gnt      = rd_gnt;
  assign bus.bram_we     = bram_we;
  assign bus.bram_addr   = addr_d;
  assign bus.bram_din    = bram_din;
  assign bus.clear_busy  = clr_busy;
  assign bus.host_rvalid = pend_q && (owner_q == OWN_HOST);
  assign bus.rd_valid    = pend_q && (owner_q == OWN_RENDER);
  assign bus.host_rdata  = bus.bram_dout;
  assign bus.rd_data     = bus.bram_dout;

`ifdef LIGHTS_ARB_STATS_EN
  logic [15:0] conf_q, conf_d;

  always_comb begin
    conf_d = conf_q;
    if (stats_clr) begin
      conf_d = '0;
    end else if (state_q == ARB_IDLE && bus.host_req && bus.rd_req && conf_q != 16'hFFFF) begin
      conf_d = conf_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) conf_q <= '0;
    else     conf_q <= conf_d;
  end

  assign conflict_cnt = conf_q;
`endif
endmodule

// File: tb/tb_lights_bram_arbiter.sv
// tb/tb_lights_bram_arbiter.sv - directed bench with a cycle-level reference model of the lights arbiter
module tb_lights_bram_arbiter;
  import lights_pkg::*;

  localparam int AW    = 10;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int MAXW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lights_bram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef LIGHTS_ARB_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] conflict_cnt;
`endif

  lights_bram_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .MAX_WAIT (MAXW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef LIGHTS_ARB_STATS_EN
    ,
    .stats_clr    (stats_clr),
    .conflict_cnt (conflict_cnt)
`endif
  );

  logic [DW-1:0] mem  [0:1023];
  logic [DW-1:0] gmem [0:1023];

  always @(posedge clk) begin
    if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_din;
    bus.bram_dout <= mem[bus.bram_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: clear words remaining, host wait count, pending read return.
  int            m_left = 0;
  int            m_wait = 0;
  int            m_conf = 0;
  logic [AW-1:0] m_addr = '0;
  logic          m_ph = 1'b0;
  logic          m_pr = 1'b0;
  logic [DW-1:0] m_pd = '0;

  always @(negedge clk) begin
    logic          hg, rg, we, idle;
    logic [AW-1:0] a;
    if (rst) begin
      check("rst_host_gnt", 32'(bus.host_gnt), 32'(0));
      check("rst_rd_gnt", 32'(bus.rd_gnt), 32'(0));
      check("rst_bram_we", 32'(bus.bram_we), 32'(0));
      m_left = 0; m_wait = 0; m_conf = 0; m_addr = '0; m_ph = 1'b0; m_pr = 1'b0;
    end else begin
      idle = (m_left == 0);
      if (!idle) begin
        hg = 1'b0; rg = 1'b0; we = 1'b1;
        a  = AW'(DEPTH - m_left);
      end else begin
        hg = bus.host_req && (!bus.rd_req || m_wait == MAXW);
        rg = bus.rd_req && !hg;
        we = hg && bus.host_we;
        a  = hg ? bus.host_addr : (rg ? bus.rd_addr : m_addr);
      end
      check("host_gnt", 32'(bus.host_gnt), 32'(hg));
      check("rd_gnt", 32'(bus.rd_gnt), 32'(rg));
      check("bram_we", 32'(bus.bram_we), 32'(we));
      check("bram_addr", 32'(bus.bram_addr), 32'(a));
      if (we) check("bram_din", 32'(bus.bram_din), idle ? 32'(bus.host_wdata) : 32'(0));
      check("clear_busy", 32'(bus.clear_busy), 32'(!idle));
      check("host_rvalid", 32'(bus.host_rvalid), 32'(m_ph));
      check("rd_valid", 32'(bus.rd_valid), 32'(m_pr));
      if (m_ph) check("host_rdata", 32'(bus.host_rdata), 32'(m_pd));
      if (m_pr) check("rd_data", 32'(bus.rd_data), 32'(m_pd));
`ifdef LIGHTS_ARB_STATS_EN
      check("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
      if (stats_clr) m_conf = 0;
      else if (idle && bus.host_req && bus.rd_req && m_conf < 65535) m_conf++;
`endif
      m_ph   = hg && !we;
      m_pr   = rg;
      m_pd   = gmem[a];
      if (we) gmem[a] = idle ? bus.host_wdata : '0;
      m_addr = a;
      if (!idle) begin
        m_left--;
      end else begin
        m_wait = (bus.host_req && !hg) ? m_wait + 1 : 0;
        if (bus.clear_start) m_left = DEPTH;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.host_req    = 1'b0;
    bus.host_we     = 1'b0;
    bus.host_addr   = '0;
    bus.host_wdata  = '0;
    bus.rd_req      = 1'b0;
    bus.rd_addr     = '0;
    bus.clear_start = 1'b0;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = a; bus.host_wdata = d;
    step();
    idle_in();
  endtask

  task automatic host_read_expect(input string name, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = a;
    step();
    idle_in();
    #1;
    check({name, "_rvalid"}, 32'(bus.host_rvalid), 32'(1));
    check({name, "_rdata"}, 32'(bus.host_rdata), 32'(d));
  endtask

  initial begin
    logic [5:0] hpat, rpat;
    logic       hg_now;
    int         nbusy;
    idle_in();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset_clear_busy", 32'(bus.clear_busy), 32'(0));
    check("reset_bram_addr", 32'(bus.bram_addr), 32'(0));
    check("reset_host_rvalid", 32'(bus.host_rvalid), 32'(0));

    // Host write then read back with the render side idle.
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 10'h012; bus.host_wdata = 16'hBEEF;
    #1;
    check("wr_host_gnt", 32'(bus.host_gnt), 32'(1));
    check("wr_bram_we", 32'(bus.bram_we), 32'(1));
    check("wr_bram_addr", 32'(bus.bram_addr), 32'h012);
    step();
    idle_in();
    host_read_expect("rd012", 10'h012, 16'hBEEF);
    for (int i = 0; i < 4; i++) host_write(AW'(i), 16'hA000 + 16'(i));

    // Render held continuously; host read is force-granted after MAX_WAIT denials.
    bus.rd_req = 1'b1;
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 10'h012;
    for (int i = 0; i < 6; i++) begin
      bus.rd_addr = AW'(i % 4);
      #1;
      hpat[5-i] = bus.host_gnt;
      rpat[5-i] = bus.rd_gnt;
      hg_now = bus.host_gnt;
      @(posedge clk);
      #1;
      if (hg_now) bus.host_req = 1'b0;
    end
    check("starve_host_pattern", 32'(hpat), 32'(6'b000010));
    check("starve_rd_pattern", 32'(rpat), 32'(6'b111101));
    idle_in();
    step();

    // Back-to-back render reads of 0..3.
    for (int k = 0; k < 5; k++) begin
      bus.rd_req  = (k < 4);
      bus.rd_addr = AW'(k % 4);
      #1;
      if (k > 0) begin
        check("b2b_rd_valid", 32'(bus.rd_valid), 32'(1));
        check("b2b_rd_data", 32'(bus.rd_data), 32'(16'hA000 + 16'(k - 1)));
        check("b2b_host_rvalid", 32'(bus.host_rvalid), 32'(0));
      end
      step();
    end
    idle_in();
    step();

    // Zero-fill with render requesting throughout.
    bus.clear_start = 1'b1;
    bus.rd_req = 1'b1;
    step();
    bus.clear_start = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.clear_busy) begin
        nbusy++;
        check("clear_no_rd_gnt", 32'(bus.rd_gnt), 32'(0));
      end
      step();
    end
    check("clear_busy_cycles", 32'(nbusy), 32'(16));
    idle_in();
    step();
    host_read_expect("rd005_after_clear", 10'h005, 16'h0000);

    // Reset in the 8th clear cycle leaves words from 7 upward untouched.
    host_write(10'h00A, 16'h1234);
    step();
    bus.clear_start = 1'b1;
    step();
    bus.clear_start = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_clear_busy", 32'(bus.clear_busy), 32'(0));
    check("abort_bram_we", 32'(bus.bram_we), 32'(0));
    step();
    host_read_expect("rd00a_after_abort", 10'h00A, 16'h1234);
    host_read_expect("rd003_after_abort", 10'h003, 16'h0000);

`ifdef LIGHTS_ARB_STATS_EN
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    bus.host_req = 1'b1; bus.host_addr = 10'h012; bus.rd_req = 1'b1;
    repeat (3) step();
    idle_in();
    check("conflict_three", 32'(conflict_cnt), 32'(3));
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    check("conflict_cleared", 32'(conflict_cnt), 32'(0));
    bus.host_req = 1'b1; bus.host_addr = 10'h012; bus.rd_req = 1'b1;
    repeat (65540) step();
    idle_in();
    check("conflict_saturated", 32'(conflict_cnt), 32'hFFFF);
`endif

    idle_in();
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lights_bram_arbiter.md
Name: lights_bram_arbiter

Overview:
- Shares the single-port lights BRAM between two requesters:
  - the host command path (UART-side, reads and writes);
  - the render pipeline (read-only, per-pixel light lookups).
- Contains a clear sequencer that zero-fills the whole BRAM on command.
- Sits between the requesters and the lights BRAM instance in top; it is the only driver of the BRAM's we/addr/din.

Parameters:
- ADDR_W, 10, BRAM address width.
- DATA_W, 16, BRAM data width.
- DEPTH, 1024, number of words cleared by the clear sequencer; must be <= 2**ADDR_W.
- MAX_WAIT, 4, consecutive denied host cycles before the host is force-granted; range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- host_req  in  1  host access request; held with its fields until granted
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  host access accepted this cycle
- host_rvalid  out  1  host read data valid
- host_rdata  out  DATA_W  host read data
- rd_req  in  1  render read request
- rd_addr  in  ADDR_W  render read address
- rd_gnt  out  1  render access accepted this cycle
- rd_valid  out  1  render read data valid
- rd_data  out  DATA_W  render read data
- clear_start  in  1  single-cycle pulse; starts the zero-fill
- clear_busy  out  1  zero-fill in progress
- bram_we  out  1  BRAM write enable
- bram_addr  out  ADDR_W  BRAM address
- bram_din  out  DATA_W  BRAM write data
- bram_dout  in  DATA_W  BRAM read data (1-cycle latency)

Behaviour:
- Reset (clk, rst synchronous active-high):
  - state = IDLE, wait_cnt = 0, clr_addr = 0.
  - All rvalid/valid outputs, host_gnt, rd_gnt, bram_we and clear_busy = 0.
  - bram_addr = 0, bram_din = 0.
- Grants are combinational from registered state and the current requests; the BRAM command is driven in the same cycle as its grant.
- FSM states:
  - IDLE → arbitrate.
  - CLEAR → sequencer owns the BRAM.
- IDLE arbitration:
  - Render has priority.
  - Host is granted when rd_req = 0, or when host_req = 1 and wait_cnt == MAX_WAIT.
  - At most one grant per cycle.
  - wait_cnt increments when host_req = 1 and host is not granted; it clears on a host grant or when host_req = 0.
- Grant effects:
  - Host granted: bram_addr = host_addr, bram_we = host_we, bram_din = host_wdata.
  - Render granted: bram_addr = rd_addr, bram_we = 0.
  - No grant: bram_we = 0 and bram_addr holds its previous value.
- Read return:
  - A one-bit owner tag is registered with each read grant.
  - One cycle after a granted read, exactly one of host_rvalid / rd_valid pulses high for one cycle, with its data = bram_dout.
  - Host writes produce no rvalid.
- Clear sequence:
  - clear_start in IDLE → CLEAR on the next cycle. Grants issued in the clear_start cycle still complete, including their read returns.
  - In CLEAR: bram_we = 1, bram_din = 0, bram_addr = clr_addr; clr_addr increments every cycle.
  - After the write at DEPTH-1: return to IDLE and reset clr_addr to 0.
  - clear_busy = 1 exactly for the DEPTH CLEAR cycles.
  - No grants during CLEAR; wait_cnt is held.
  - clear_start while busy is ignored.
- Simultaneous rd_req and host_req at wait_cnt == MAX_WAIT: host wins, render is denied for that cycle.
- Reset mid-CLEAR: abort immediately to the reset state; partially cleared contents remain.
- Requests arriving during reset: not granted.

Optional Feature:
- Macro: LIGHTS_ARB_STATS_EN.
- With the macro:
  - Adds output port conflict_cnt [15:0]: a saturating count of cycles where host_req and rd_req were both high in IDLE.
  - Adds input port stats_clr: synchronous clear to 0.
  - Reset value of conflict_cnt is 0; it saturates at 16'hFFFF.
- Without the macro: neither port exists and no counter logic is generated.

Decomposition:
- Package lights_pkg holds:
  - LIGHTS_ADDR_W, LIGHTS_DATA_W, LIGHTS_DEPTH;
  - the FSM state enum (ARB_IDLE, ARB_CLEAR);
  - the owner tag enum (OWN_HOST, OWN_RENDER).
- One natural sub-module: lights_clear_seq (clr_addr counter, busy flag, done pulse). The arbiter instantiates it.

Test Plan:
- Host write 0x0012 → 0xBEEF with rd_req = 0 → host_gnt same cycle, bram_we = 1, bram_addr = 0x012; then host read 0x012 → host_rvalid next cycle, host_rdata = 0xBEEF.
- rd_req held continuously plus host read, MAX_WAIT = 4 → rd_gnt for 4 cycles, host_gnt on the 5th, rd_gnt resumes on the 6th; exactly one rvalid per grant.
- Back-to-back render reads of 0x000..0x003 → rd_valid on 4 consecutive cycles, data in address order, host_rvalid stays 0.
- clear_start with DEPTH = 16 → clear_busy high exactly 16 cycles, addresses 0..15 written with 0, no grants meanwhile; a subsequent read of 0x005 returns 0.
- rst asserted at the 8th CLEAR cycle → next cycle clear_busy = 0, bram_we = 0; address 0x00A retains its pre-clear value.
- LIGHTS_ARB_STATS_EN: 3 cycles of dual requests → conflict_cnt = 3; stats_clr → 0; forced count to 0xFFFF holds at 0xFFFF.
